tick_monitor: RTL and testbench

- Receive-side checker for the single-cycle strobe produced by the team's clock-gate/tick generator.
- Measures the cycle interval between successive strobes and publishes each measurement through a valid/ready holding register.
- Declares lock after a run of correct periods, and flags period mismatches and missing strobes.
- Sits beside every tick consumer so that tick-rate faults are visible to status/CSR logic.

---
 rtl/tick_monitor_pkg.sv | 25 ++
 rtl/tick_hold_reg.sv | 46 ++++
 rtl/tick_monitor.sv | 151 +++++++++++++++
 tb/tb_tick_monitor.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/tick_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tick_monitor_pkg
// Purpose  : Shared types and helpers for the tick-rate monitor.
//            - state_t: monitor FSM states (IDLE, MEASURE, LOCKED)
//            - match_cnt_width(): bits needed to count up to LOCK_COUNT
// Revision : 1.0  initial release
// ============================================================================
package tick_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,   // no reference strobe yet; nothing to measure
        MEASURE = 2'd1,   // measuring intervals, building up the match run
        LOCKED  = 2'd2    // LOCK_COUNT good intervals seen, watching for faults
    } state_t;

    // The match counter saturates at LOCK_COUNT, so it must hold that value.
    function automatic int match_cnt_width(input int lock_count);
        int w;
        w = $clog2(lock_count + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : tick_monitor_pkg
`default_nettype wire

// File: rtl/tick_hold_reg.sv
`default_nettype none
// ============================================================================
// Module   : tick_hold_reg
// Purpose  : One-entry valid/ready holding register. A new load always
//            overwrites the stored word; if the previous word had not been
//            consumed, the sticky dropped flag is raised.
// Ports    : clk, reset     - clock, synchronous active-high reset
//            load,load_data - write strobe and data
//            out_data       - held word
//            out_valid      - held word not yet consumed
//            out_ready      - consumer accepts when out_valid & out_ready
//            dropped        - sticky: an unconsumed word was overwritten
// Revision : 1.0  initial release
// ============================================================================
module tick_hold_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_data,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         dropped
);

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            dropped   <= 1'b0;
        end else if (load) begin
            // A simultaneous hand-off consumes the old word, so it is not lost.
            out_data  <= load_data;
            out_valid <= 1'b1;
            if (out_valid && !out_ready) begin
                dropped <= 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule : tick_hold_reg
`default_nettype wire

// File: rtl/tick_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tick_monitor
// Purpose  : Receive-side checker for a single-cycle tick strobe. Measures
//            the interval between strobes, publishes each measurement through
//            a holding register, declares lock after LOCK_COUNT consecutive
//            PERIOD-length intervals, and flags mismatches and missing strobes.
// Ports    : clk, reset    - clock, synchronous active-high reset
//            tick_in       - strobe input, one event per high cycle
//            period_out    - last measured interval in cycles
//            period_valid  - period_out holds an unconsumed measurement
//            period_ready  - consumer accept
//            locked        - lock achieved, no error since
//            err_mismatch  - 1-cycle pulse: wrong interval while locked
//            err_timeout   - 1-cycle pulse: strobe missing
//            dropped       - sticky: unconsumed measurement overwritten
// Revision : 1.0  initial release
// ============================================================================
module tick_monitor
    import tick_monitor_pkg::*;
#(
    parameter int PERIOD     = 10,
    parameter int TIMEOUT    = 64,
    parameter int LOCK_COUNT = 4,
    parameter int W          = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tick_in,
    output logic [W-1:0] period_out,
    output logic         period_valid,
    input  logic         period_ready,
    output logic         locked,
    output logic         err_mismatch,
    output logic         err_timeout,
    output logic         dropped
);

    localparam int              C_MW        = match_cnt_width(LOCK_COUNT);
    localparam logic [W-1:0]    C_PERIOD    = W'(PERIOD);
    localparam logic [W-1:0]    C_CNT_LAST  = W'(TIMEOUT - 1);
    localparam logic [C_MW-1:0] C_LOCK      = C_MW'(LOCK_COUNT);
    localparam logic [C_MW-1:0] C_LOCK_M1   = C_MW'(LOCK_COUNT - 1);

    state_t          r_state;
    logic [W-1:0]    r_cnt;
    logic [C_MW-1:0] r_match_cnt;

    logic [W-1:0]    w_meas;
    logic            w_meas_load;
    logic            w_meas_ok;
    logic            w_timeout;

    // cnt counts the cycles since the last strobe minus one, so the interval
    // ending on the current strobe is cnt+1 (back-to-back strobes give 1).
    assign w_meas      = r_cnt + W'(1);
    assign w_meas_ok   = (w_meas == C_PERIOD);
    // A strobe on the timeout cycle wins, hence the !tick_in qualifier.
    assign w_timeout   = (r_cnt == C_CNT_LAST) && !tick_in;
    // IDLE strobes only start the first interval; they carry no measurement.
    assign w_meas_load = (r_state != IDLE) && tick_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_match_cnt  <= '0;
            locked       <= 1'b0;
            err_mismatch <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            err_mismatch <= 1'b0;
            err_timeout  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (tick_in) begin
                        r_cnt   <= '0;
                        r_state <= MEASURE;
                    end
                end

                MEASURE: begin
                    if (tick_in) begin
                        r_cnt <= '0;
                        if (w_meas_ok) begin
                            if (r_match_cnt == C_LOCK_M1) begin
                                r_match_cnt <= C_LOCK;
                                locked      <= 1'b1;
                                r_state     <= LOCKED;
                            end else begin
                                r_match_cnt <= r_match_cnt + C_MW'(1);
                            end
                        end else begin
                            r_match_cnt <= '0;
                        end
                    end else if (w_timeout) begin
                        err_timeout <= 1'b1;
                        locked      <= 1'b0;
                        r_match_cnt <= '0;
                        r_cnt       <= '0;
                        r_state     <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + W'(1);
                    end
                end

                LOCKED: begin
                    if (tick_in) begin
                        r_cnt <= '0;
                        if (!w_meas_ok) begin
                            err_mismatch <= 1'b1;
                            locked       <= 1'b0;
                            r_match_cnt  <= '0;
                            r_state      <= MEASURE;
                        end
                    end else if (w_timeout) begin
                        err_timeout <= 1'b1;
                        locked      <= 1'b0;
                        r_match_cnt <= '0;
                        r_cnt       <= '0;
                        r_state     <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + W'(1);
                    end
                end

                default: begin
                    r_state     <= IDLE;
                    r_cnt       <= '0;
                    r_match_cnt <= '0;
                    locked      <= 1'b0;
                end
            endcase
        end
    end

    tick_hold_reg #(
        .W (W)
    ) u_hold (
        .clk       (clk),
        .reset     (reset),
        .load      (w_meas_load),
        .load_data (w_meas),
        .out_data  (period_out),
        .out_valid (period_valid),
        .out_ready (period_ready),
        .dropped   (dropped)
    );

endmodule : tick_monitor
`default_nettype wire

// File: tb/tb_tick_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_tick_monitor
// Purpose  : Self-checking bench for tick_monitor. Directed scenarios followed
//            by randomized strobe/ready traffic, all compared every cycle
//            against a time-stamp based reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_tick_monitor;

    localparam int PERIOD     = 10;
    localparam int TIMEOUT    = 64;
    localparam int LOCK_COUNT = 4;
    localparam int W          = 32;

    logic         clk;
    logic         reset;
    logic         tick_in;
    logic [W-1:0] period_out;
    logic         period_valid;
    logic         period_ready;
    logic         locked;
    logic         err_mismatch;
    logic         err_timeout;
    logic         dropped;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: remembers the absolute cycle of the last strobe and
    // derives intervals by subtraction.
    int cyc       = 0;
    bit have_ref  = 0;
    int last_tick = 0;
    int run       = 0;
    bit e_locked  = 0;
    bit e_mis     = 0;
    bit e_to      = 0;
    int e_val     = 0;
    bit e_valid   = 0;
    bit e_drop    = 0;

    tick_monitor #(
        .PERIOD     (PERIOD),
        .TIMEOUT    (TIMEOUT),
        .LOCK_COUNT (LOCK_COUNT),
        .W          (W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .tick_in      (tick_in),
        .period_out   (period_out),
        .period_valid (period_valid),
        .period_ready (period_ready),
        .locked       (locked),
        .err_mismatch (err_mismatch),
        .err_timeout  (err_timeout),
        .dropped      (dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model_update(input bit tk, input bit rdy, input bit rs);
        bit pub;
        int m;
        int elapsed;
        pub = 0;
        m   = 0;
        if (rs) begin
            have_ref = 0; run = 0; e_locked = 0; e_mis = 0; e_to = 0;
            e_val = 0; e_valid = 0; e_drop = 0;
        end else begin
            e_mis = 0;
            e_to  = 0;
            if (!have_ref) begin
                if (tk) begin
                    have_ref  = 1;
                    last_tick = cyc;
                end
            end else begin
                elapsed = cyc - last_tick;
                if (tk) begin
                    pub       = 1;
                    m         = elapsed;
                    last_tick = cyc;
                    if (e_locked) begin
                        if (m != PERIOD) begin
                            e_mis = 1; e_locked = 0; run = 0;
                        end
                    end else if (m == PERIOD) begin
                        run++;
                        if (run >= LOCK_COUNT) e_locked = 1;
                    end else begin
                        run = 0;
                    end
                end else if (elapsed == TIMEOUT) begin
                    e_to = 1; e_locked = 0; run = 0; have_ref = 0;
                end
            end
            if (pub) begin
                if (e_valid && !rdy) e_drop = 1;
                e_val   = m;
                e_valid = 1;
            end else if (e_valid && rdy) begin
                e_valid = 0;
            end
        end
    endtask

    task automatic step(input bit tk, input bit rdy, input bit rs);
        @(negedge clk);
        tick_in      = tk;
        period_ready = rdy;
        reset        = rs;
        @(posedge clk);
        cyc++;
        model_update(tk, rdy, rs);
        #1;
        check("period_out",   period_out,   e_val);
        check("period_valid", period_valid, e_valid);
        check("locked",       locked,       e_locked);
        check("err_mismatch", err_mismatch, e_mis);
        check("err_timeout",  err_timeout,  e_to);
        check("dropped",      dropped,      e_drop);
        check("err_exclusive", err_mismatch & err_timeout, 1'b0);
    endtask

    // len-1 quiet cycles followed by one strobe cycle.
    task automatic interval(input int len, input bit rdy);
        for (int i = 1; i < len; i++) step(1'b0, rdy, 1'b0);
        step(1'b1, rdy, 1'b0);
    endtask

    initial begin
        tick_in      = 1'b0;
        period_ready = 1'b0;
        reset        = 1'b1;

        // Reset state
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);

        // Steady 10-cycle strobe, consumer always ready: lock after 4 intervals
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) interval(PERIOD, 1'b1);

        // One long interval while locked, then relock
        interval(11, 1'b1);
        for (int i = 0; i < 5; i++) interval(PERIOD, 1'b1);

        // Strobe on the exact timeout cycle wins (m=TIMEOUT, mismatch)
        interval(TIMEOUT, 1'b1);
        for (int i = 0; i < 5; i++) interval(PERIOD, 1'b1);

        // Strobe stops: timeout, then restart from IDLE
        for (int i = 0; i < 80; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        interval(PERIOD, 1'b1);
        interval(PERIOD, 1'b1);

        // Consumer stalls over 10 then 7: overwrite sets dropped
        interval(PERIOD, 1'b0);
        interval(7, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);

        // Back-to-back strobes with a consumer ready on every load
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        interval(PERIOD, 1'b1);
        for (int i = 1; i < PERIOD; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);

        // Reset mid-interval while locked with an unconsumed measurement
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) interval(PERIOD, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        interval(PERIOD, 1'b1);
        interval(PERIOD, 1'b1);

        // Randomized traffic: mostly nominal, some short, some near timeout
        while (cyc < 6000) begin
            int r;
            int len;
            r = int'($urandom % 10);
            if (r < 6)      len = PERIOD;
            else if (r < 8) len = int'($urandom_range(1, 20));
            else            len = int'($urandom_range(TIMEOUT - 8, TIMEOUT + 6));
            for (int i = 1; i <= len; i++) begin
                step((i == len), (($urandom % 4) != 0), (($urandom % 700) == 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_tick_monitor
`default_nettype wire
